// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// The LOCK state is only reachable when FIFO_WR_ARB_LOCK_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Round-robin successor of idx within 0..n-1.
  function automatic int rr_wrap(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// wrapping past N-1 back to 0. Reusable by any arbiter built on a priority pointer.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] id_o,
  output logic          any_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    any_o = 1'b0;
    // Scan downward so the lowest rotated offset is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IW'(i);
        any_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    id_o  = sum[IW-1:0];
    gnt_o = any_o ? (N'(1) << id_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_LOCK_EN to hold the port for a requester until its req_last beat.
//
// state | meaning
// ARB   | every eligible requester competes from ptr onward
// LOCK  | only owner may be granted until it sends a req_last beat
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_WR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [ID_WIDTH-1:0]           gnt_id,
  output logic                          gnt_valid
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_WIDTH-1:0] pick_id;
  logic                pick_any;
  logic                grant_en;
  logic [ID_WIDTH-1:0] ptr_next;

`ifdef FIFO_WR_ARB_LOCK_EN
  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;

  assign eligible = (state_q == LOCK) ? (req & (NUM_REQ'(1) << owner_q)) : req;
`else
  assign eligible = req;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  // Reset gates the grant combinationally so outputs drop without a clock edge.
  assign grant_en = reset & ~full & pick_any;
  assign gnt      = grant_en ? pick_gnt : '0;
  assign wr       = |gnt;
  assign ptr_next = ID_WIDTH'(rr_wrap(32'(pick_id), NUM_REQ));

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = grant_en;
`ifdef FIFO_WR_ARB_LOCK_EN
    state_d     = state_q;
    owner_d     = owner_q;
    if (grant_en) begin
      gnt_id_d = pick_id;
      case (state_q)
        ARB: begin
          ptr_d = ptr_next;
          if (~|(req_last & pick_gnt)) begin
            state_d = LOCK;
            owner_d = pick_id;
          end
        end
        LOCK: begin
          if (|(req_last & pick_gnt)) begin
            state_d = ARB;
            ptr_d   = ptr_next;
          end
        end
        default: state_d = ARB;
      endcase
    end
`else
    if (grant_en) begin
      gnt_id_d = pick_id;
      ptr_d    = ptr_next;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef FIFO_WR_ARB_LOCK_EN
      state_q     <= ARB;
      owner_q     <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef FIFO_WR_ARB_LOCK_EN
      state_q     <= state_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (default build, no packet lock).
// A behavioural round-robin model predicts grants, write data and registered status.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          full;
  logic [N-1:0]  gnt;
  logic          wr;
  logic [DW-1:0] w_data;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .full      (full),
    .gnt       (gnt),
    .wr        (wr),
    .w_data    (w_data),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: next priority start, last winner, winner-last-cycle flag.
  int ptr_m   = 0;
  int id_m    = 0;
  bit valid_m = 0;
  logic [DW-1:0] data_m [N];
  logic [N-1:0]  obs_gnt;
  logic [DW-1:0] fifo_q [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int winner(logic [N-1:0] r, logic f, logic rst, int p);
    if (!rst || f) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = data_m[i];
  endtask

  // Called just after a falling edge with inputs applied; returns there one cycle later.
  task automatic cycle(string tag);
    int w;
    pack_data();
    #1;
    w = winner(req, full, reset, ptr_m);
    obs_gnt = gnt;
    chk({tag, ".gnt"},    32'(gnt),    (w < 0) ? 32'd0 : (32'd1 << w));
    chk({tag, ".wr"},     32'(wr),     32'(w >= 0));
    chk({tag, ".w_data"}, 32'(w_data), (w < 0) ? 32'd0 : 32'(data_m[w]));
    if (w >= 0) fifo_q.push_back(data_m[w]);
    @(posedge clk);
    if (!reset) begin
      ptr_m = 0; id_m = 0; valid_m = 0;
    end else if (w >= 0) begin
      ptr_m = (w + 1) % N; id_m = w; valid_m = 1;
    end else begin
      valid_m = 0;
    end
    #1;
    chk({tag, ".gnt_id"},    32'(gnt_id),    32'(id_m));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(valid_m));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    ptr_m = 0; id_m = 0; valid_m = 0;
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < N; i++) data_m[i] = DW'(8'h10 * (i + 1) + i);
    reset = 1'b0; req = 4'b1111; full = 1'b0; pack_data();

    // Reset held low with every request asserted: nothing is granted.
    @(negedge clk);
    cycle("rst0");
    cycle("rst1");

    // All request: strict rotation 0,1,2,3,0.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("rot");
      chk("rot.seq", 32'(obs_gnt), 32'(seq[i]));
    end

    // Sparse requests from ptr=0: only 1 and 3 alternate.
    do_reset();
    req = 4'b1010;
    cycle("sparse0"); chk("sparse0.seq", 32'(obs_gnt), 32'b0010);
    cycle("sparse1"); chk("sparse1.seq", 32'(obs_gnt), 32'b1000);
    cycle("sparse2"); chk("sparse2.seq", 32'(obs_gnt), 32'b0010);

    // Full stalls for three cycles, then the waiting requester goes through at once.
    req = 4'b0100; full = 1'b1;
    for (int i = 0; i < 3; i++) cycle("full");
    full = 1'b0;
    cycle("unfull"); chk("unfull.seq", 32'(obs_gnt), 32'b0100);

    // Single requester streams five words back to back, in order.
    fifo_q.delete();
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      data_m[3] = DW'(8'hA0 + i);
      cycle("stream");
    end
    chk("stream.count", 32'(fifo_q.size()), 32'd5);
    for (int i = 0; i < 5 && fifo_q.size() > 0; i++) begin
      chk("stream.order", 32'(fifo_q.pop_front()), 32'(8'hA0 + i));
    end

    // Asynchronous reset between clock edges drops everything immediately.
    req = 4'b0100; pack_data();
    #1;
    chk("async.pre_gnt",   32'(gnt),       32'b0100);
    chk("async.pre_valid", 32'(gnt_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async.gnt",   32'(gnt),       32'd0);
    chk("async.wr",    32'(wr),        32'd0);
    chk("async.wdata", 32'(w_data),    32'd0);
    chk("async.valid", 32'(gnt_valid), 32'd0);
    chk("async.id",    32'(gnt_id),    32'd0);
    @(negedge clk);
    ptr_m = 0; id_m = 0; valid_m = 0;
    reset = 1'b1; req = 4'b1111;
    cycle("post_rst"); chk("post_rst.seq", 32'(obs_gnt), 32'b0001);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req  = N'($urandom);
      full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) data_m[k] = DW'($urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the fifo block among NUM_REQ requesters.
- Sits between the requesters and the fifo. It drives the fifo `wr` and `w_data` inputs and observes the fifo `full` output.
- Grant is same-cycle (combinational from a registered priority pointer). Arbitration state is registered.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, fifo word width; must match the fifo instance.
- ID_WIDTH, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; level, held until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  fifo full flag.
- gnt  out  NUM_REQ  one-hot grant; the word is accepted this cycle.
- wr  out  1  fifo write strobe; equals |gnt.
- w_data  out  DATA_WIDTH  req_data slice of the granted requester; 0 when wr=0.
- gnt_id  out  ID_WIDTH  registered index of the most recent grant.
- gnt_valid  out  1  registered; high the cycle after any grant.

Behaviour:
- Reset (reset=0, async) forces:
  - ptr=0, gnt_id=0, gnt_valid=0.
  - State ARB (lock feature only).
  - Combinational outputs follow from req/full: no grant while reset is low, so gnt=0, wr=0, w_data=0.
- Priority order each cycle: ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. The first requester with req=1 wins.
- Grant condition: full=0 and at least one eligible req. At most one gnt bit is high.
- Handshake: a beat transfers when req[i] and gnt[i] are both high in the same cycle. The requester may change data or drop req the next cycle.
- full=1:
  - gnt=0, wr=0.
  - ptr, gnt_id and state are unchanged.
  - gnt_valid <= 0.
- On a grant to requester i:
  - ptr <= (i+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
  - gnt_id <= i.
  - gnt_valid <= 1.
- No requests: gnt=0, ptr held, gnt_valid <= 0.
- The arbiter never writes while full=1, so the fifo's own write qualification is never exercised.
- Simultaneous read by the fifo consumer is irrelevant: the arbiter looks only at full in the current cycle.
- ptr arithmetic is ID_WIDTH bits wide. For non-power-of-2 NUM_REQ, wrap explicitly; values ≥ NUM_REQ never occur.

Optional Feature:
- Macro: FIFO_WR_ARB_LOCK_EN.
- With the macro defined:
  - Adds input `req_last`, width NUM_REQ: the beat is the final word of a packet.
  - Two-state FSM, ARB and LOCK, with a registered `owner`.
  - ARB, grant to i with req_last[i]=0: go to LOCK, owner <= i.
  - ARB, grant to i with req_last[i]=1: stay in ARB.
  - LOCK: only the owner is eligible. Other requesters get gnt=0 even if the owner's req=0 (bubble allowed). full stalls as in ARB.
  - LOCK, grant with req_last[owner]=1: return to ARB, ptr <= owner+1.
  - LOCK, grant without last: stay in LOCK, ptr unchanged.
  - Reset mid-packet returns to ARB with ptr=0.
- Without the macro: no req_last port, no FSM; every beat is arbitrated independently.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state typedef {ARB, LOCK};
  - the function rr_wrap(idx, n) for pointer increment.
- Sub-module rr_pick:
  - combinational rotate/priority-encode/unrotate;
  - inputs: req vector and ptr;
  - outputs: one-hot grant and index;
  - reusable by other arbiters in the design.

Test Plan:
- Reset held low with req=4'b1111 → gnt=0, wr=0. After release with full=0 → gnt=4'b0001, then 0010, 0100, 1000, 0001 on consecutive cycles; gnt_id follows 0,1,2,3,0 one cycle late.
- req=4'b1010, ptr=0 → gnt=0010, then 1000, then 0010. Requesters 0 and 2 are never granted.
- full=1 for 3 cycles with req=4'b0100 → gnt=0, wr=0, ptr held. full drops → gnt=0100 and w_data=req_data[23:16] in the same cycle.
- Single requester 3 with req held 5 cycles, data 0xA0..0xA4 → wr high all 5 cycles; fifo r_data drains 0xA0..0xA4 in order.
- Assert reset asynchronously mid-cycle while gnt=0100 → gnt, wr and gnt_valid drop immediately without a clock edge; next grant after release starts at requester 0.
- (LOCK_EN) Requester 1 sends 3 beats, last on beat 3, while req[0] and req[2] are held → gnt=0010 ×3, then 0100, then 0001. A 1-cycle req[1] gap mid-packet produces a bubble with gnt=0.
